ce_period_monitor: RTL and testbench
====================================

// Module: ce_period_monitor
// PURPOSE
//   Receive-side companion to the clock-enable generator. Measures I_CLK cycles between
//   successive rising edges of a strobe (CE pulse or slow square wave) and reports each period.
//   Declares lock when the period stays within tolerance of an expected value.
//   Declares timeout when edges stop arriving.
//   Used to check CE sources and external tick inputs at runtime.
// PARAMETERS
//   P_WIDTH    17            bit width of period counter and O_PERIOD
//   P_EXPECT   17'd100000    expected period in I_CLK cycles
//   P_TOL      17'd2         allowed |period - P_EXPECT|, inclusive
//   P_LOCK_N   3             consecutive in-tolerance periods required for lock (1..7)
//   P_TIMEOUT  17'd131071    cycles without an edge before timeout; 2 <= P_TIMEOUT < 2**P_WIDTH
// PORTS
//   I_CLK      in   1        clock
//   I_RST      in   1        reset; synchronous, active-high
//   I_PULSE    in   1        strobe; already synchronous to I_CLK; only rising edges count
//   O_PERIOD   out  P_WIDTH  last measured period; held until the next measurement
//   O_VALID    out  1        1-cycle pulse; O_PERIOD updated in the same cycle
//   O_LOCK     out  1        level; high while lock criterion is met
//   O_TIMEOUT  out  1        1-cycle pulse when timeout fires
// BEHAVIOUR
//   Reset:
//   - State S_IDLE; counter, match count and delayed-pulse register = 0.
//   - O_PERIOD, O_VALID, O_LOCK, O_TIMEOUT all = 0.
//   - Reset mid-measurement discards the partial count and clears lock.
//   Edge detect:
//   - edge = I_PULSE & ~r_pulse_d.
//   - r_pulse_d resets to 0, so I_PULSE held high through reset release counts as an edge
//     on the first cycle after reset.
//   - A long-high pulse counts once.
//   S_IDLE:
//   - r_cnt held at 0.
//   - On edge: r_cnt <= 1, go to S_RUN. No O_VALID.
//   S_RUN, edge:
//   - O_PERIOD <= r_cnt; O_VALID <= 1 next cycle; r_cnt <= 1.
//   - Period definition: edges at cycles t and t+N give O_PERIOD = N.
//   - Latency: O_VALID is high in cycle t+N+1.
//   S_RUN, no edge, r_cnt == P_TIMEOUT:
//   - Go to S_IDLE; r_cnt <= 0; O_TIMEOUT <= 1 for one cycle.
//   - Clear match count and O_LOCK in the same cycle as O_TIMEOUT.
//   S_RUN, no edge, r_cnt < P_TIMEOUT: r_cnt <= r_cnt + 1. r_cnt never wraps.
//   Edge and r_cnt == P_TIMEOUT in the same cycle: the edge wins.
//   - Report O_PERIOD = P_TIMEOUT; no timeout; stay in S_RUN.
//   Lock check (evaluated on each measurement):
//   - diff = |r_cnt - P_EXPECT|, computed in P_WIDTH+1 bits unsigned; no overflow.
//   - diff <= P_TOL: match count increments, saturating at P_LOCK_N.
//     O_LOCK <= (new count == P_LOCK_N).
//   - Otherwise: match count <= 0, O_LOCK <= 0.
//   - O_LOCK changes only in the O_VALID cycle or the O_TIMEOUT cycle.
//   All outputs are registered. O_VALID and O_TIMEOUT are never high in the same cycle.
// TESTING
//   1. Clock-enable generator (P_DIV=4) drives I_PULSE
//      -> first O_VALID one cycle after the 2nd edge, O_PERIOD=4;
//         thereafter O_VALID every 4 cycles.
//   2. P_EXPECT=100, P_TOL=2, P_LOCK_N=3; periods 99,101,100
//      -> O_LOCK rises with the 3rd O_VALID.
//      Then period 103 -> O_LOCK falls with that O_VALID; O_PERIOD=103.
//   3. P_TIMEOUT=50; last edge at cycle t, then no edges
//      -> O_TIMEOUT high only at t+51; O_LOCK=0.
//      Next edge gives no O_VALID; the following edge, 7 cycles later, gives O_PERIOD=7.
//   4. P_TIMEOUT=50; edges exactly 50 cycles apart
//      -> O_PERIOD=50 with O_VALID each time; O_TIMEOUT never asserts.
//   5. I_RST for 1 cycle midway through a 100-cycle period
//      -> all outputs 0 the next cycle; first edge after reset gives no O_VALID;
//         second edge gives the correct period.
//   6. I_PULSE high 10 cycles, low 10, repeating
//      -> O_PERIOD=20 steadily; a single O_VALID per rising edge.

Source files
------------

// File: rtl/ce_period_monitor.sv
// ce_period_monitor
// Measures the number of I_CLK cycles between rising edges of I_PULSE and reports each
// period. Lock is declared after P_LOCK_N consecutive periods within P_TOL of P_EXPECT.
// A timeout pulse fires when no edge arrives within P_TIMEOUT cycles.
module ce_period_monitor #(
  parameter int unsigned         P_WIDTH   = 17,
  parameter logic [P_WIDTH-1:0]  P_EXPECT  = P_WIDTH'(100000),
  parameter logic [P_WIDTH-1:0]  P_TOL     = P_WIDTH'(2),
  parameter int unsigned         P_LOCK_N  = 3,
  parameter logic [P_WIDTH-1:0]  P_TIMEOUT = P_WIDTH'(131071)
) (
  input  logic               I_CLK,
  input  logic               I_RST,
  input  logic               I_PULSE,
  output logic [P_WIDTH-1:0] O_PERIOD,
  output logic               O_VALID,
  output logic               O_LOCK,
  output logic               O_TIMEOUT
);

  // Match counter only needs to reach 7.
  localparam int unsigned LW = 3;
  // Difference is formed one bit wider than the counter so it cannot overflow.
  localparam int unsigned DW = P_WIDTH + 1;

  localparam logic [LW-1:0]      LOCK_N   = LW'(P_LOCK_N);
  localparam logic [P_WIDTH-1:0] CNT_ONE  = P_WIDTH'(1);
  localparam logic [DW-1:0]      EXP_EXT  = {1'b0, P_EXPECT};
  localparam logic [DW-1:0]      TOL_EXT  = {1'b0, P_TOL};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             nx_state;

  logic               r_pulse_d;
  logic [P_WIDTH-1:0] r_cnt;
  logic [LW-1:0]      r_match;

  logic [P_WIDTH-1:0] nx_cnt;
  logic [LW-1:0]      nx_match;
  logic [P_WIDTH-1:0] nx_period;
  logic               nx_valid;
  logic               nx_lock;
  logic               nx_timeout;

  logic               pulse_rise;
  logic               cnt_at_to;
  logic [DW-1:0]      cnt_ext;
  logic [DW-1:0]      diff;
  logic               in_tol;
  logic [LW-1:0]      match_inc;

  // Rising-edge detect, timeout compare and tolerance check of the current count.
  always_comb begin
    pulse_rise = I_PULSE & ~r_pulse_d;
    cnt_at_to  = (r_cnt == P_TIMEOUT);
    cnt_ext    = {1'b0, r_cnt};
    if (cnt_ext >= EXP_EXT) begin
      diff = cnt_ext - EXP_EXT;
    end else begin
      diff = EXP_EXT - cnt_ext;
    end
    in_tol = (diff <= TOL_EXT);
    if (r_match >= LOCK_N) begin
      match_inc = LOCK_N;
    end else begin
      match_inc = r_match + LW'(1);
    end
  end

  // State register.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= nx_state;
    end
  end

  // Next-state logic: an edge starts a measurement, a silent timeout ends it.
  always_comb begin
    nx_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (pulse_rise) begin
          nx_state = S_RUN;
        end
      end
      S_RUN: begin
        if (!pulse_rise && cnt_at_to) begin
          nx_state = S_IDLE;
        end
      end
      default: begin
        nx_state = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values; an edge takes priority over the timeout.
  always_comb begin
    nx_cnt     = r_cnt;
    nx_match   = r_match;
    nx_period  = O_PERIOD;
    nx_valid   = 1'b0;
    nx_lock    = O_LOCK;
    nx_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        nx_cnt = '0;
        if (pulse_rise) begin
          nx_cnt = CNT_ONE;
        end
      end
      S_RUN: begin
        if (pulse_rise) begin
          nx_period = r_cnt;
          nx_valid  = 1'b1;
          nx_cnt    = CNT_ONE;
          if (in_tol) begin
            nx_match = match_inc;
            nx_lock  = (match_inc == LOCK_N);
          end else begin
            nx_match = '0;
            nx_lock  = 1'b0;
          end
        end else if (cnt_at_to) begin
          nx_cnt     = '0;
          nx_timeout = 1'b1;
          nx_match   = '0;
          nx_lock    = 1'b0;
        end else begin
          nx_cnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        nx_cnt = '0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_pulse_d <= 1'b0;
      r_cnt     <= '0;
      r_match   <= '0;
      O_PERIOD  <= '0;
      O_VALID   <= 1'b0;
      O_LOCK    <= 1'b0;
      O_TIMEOUT <= 1'b0;
    end else begin
      r_pulse_d <= I_PULSE;
      r_cnt     <= nx_cnt;
      r_match   <= nx_match;
      O_PERIOD  <= nx_period;
      O_VALID   <= nx_valid;
      O_LOCK    <= nx_lock;
      O_TIMEOUT <= nx_timeout;
    end
  end

endmodule

// File: tb/tb_ce_period_monitor.sv
// Testbench for ce_period_monitor: directed vector table, hand-written corner sequences
// and randomized pulse trains checked cycle-by-cycle against an edge-timestamp model.
module tb_ce_period_monitor;

  localparam int unsigned W      = 17;
  localparam int          EXPECT = 100;
  localparam int          TOL    = 2;
  localparam int          LOCKN  = 3;
  localparam int          TMO    = 150;

  logic         I_CLK   = 1'b0;
  logic         I_RST   = 1'b1;
  logic         I_PULSE = 1'b0;
  logic [W-1:0] O_PERIOD;
  logic         O_VALID;
  logic         O_LOCK;
  logic         O_TIMEOUT;

  always #5 I_CLK = ~I_CLK;

  ce_period_monitor #(
    .P_WIDTH  (W),
    .P_EXPECT (17'd100),
    .P_TOL    (17'd2),
    .P_LOCK_N (3),
    .P_TIMEOUT(17'd150)
  ) dut (
    .I_CLK    (I_CLK),
    .I_RST    (I_RST),
    .I_PULSE  (I_PULSE),
    .O_PERIOD (O_PERIOD),
    .O_VALID  (O_VALID),
    .O_LOCK   (O_LOCK),
    .O_TIMEOUT(O_TIMEOUT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: timestamps of edges rather than a running counter.
  int cyc       = 0;
  int last_edge = 0;
  bit armed     = 1'b0;
  bit m_prev    = 1'b0;
  int m_match   = 0;
  int m_period  = 0;
  bit m_valid   = 1'b0;
  bit m_lock    = 1'b0;
  bit m_to      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic p, input logic r);
    bit rise;
    int n;
    int d;
    cyc++;
    m_valid = 1'b0;
    m_to    = 1'b0;
    if (r) begin
      armed    = 1'b0;
      m_prev   = 1'b0;
      m_period = 0;
      m_lock   = 1'b0;
      m_match  = 0;
    end else begin
      rise   = p && !m_prev;
      m_prev = p;
      if (rise) begin
        if (armed) begin
          n        = cyc - last_edge;
          m_period = n;
          m_valid  = 1'b1;
          d        = (n > EXPECT) ? (n - EXPECT) : (EXPECT - n);
          if (d <= TOL) begin
            m_match = (m_match < LOCKN) ? m_match + 1 : LOCKN;
            m_lock  = (m_match == LOCKN);
          end else begin
            m_match = 0;
            m_lock  = 1'b0;
          end
        end
        armed     = 1'b1;
        last_edge = cyc;
      end else if (armed && (cyc - last_edge == TMO)) begin
        armed   = 1'b0;
        m_to    = 1'b1;
        m_match = 0;
        m_lock  = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic tick(input logic p, input logic r);
    I_PULSE = p;
    I_RST   = r;
    @(posedge I_CLK);
    model_step(p, r);
    #1;
    chk("model", 64'({O_PERIOD, O_VALID, O_LOCK, O_TIMEOUT}),
        64'({W'(m_period), m_valid, m_lock, m_to}));
  endtask

  // Single-cycle pulse whose rising edge lands gap cycles after the previous one.
  task automatic pulse_after(input int gap);
    repeat (gap - 1) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  typedef struct {
    int gap;
    bit exp_valid;
    int exp_period;
    bit exp_lock;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int to_at;
    int to_cnt;
    bit lock_at_to;
    int nv;
    int bad;
    int sel;
    int total;
    int hi;

    tbl.push_back(vec_t'{5,   1'b0, 0,   1'b0});
    tbl.push_back(vec_t'{4,   1'b1, 4,   1'b0});
    tbl.push_back(vec_t'{4,   1'b1, 4,   1'b0});
    tbl.push_back(vec_t'{4,   1'b1, 4,   1'b0});
    tbl.push_back(vec_t'{99,  1'b1, 99,  1'b0});
    tbl.push_back(vec_t'{101, 1'b1, 101, 1'b0});
    tbl.push_back(vec_t'{100, 1'b1, 100, 1'b1});
    tbl.push_back(vec_t'{103, 1'b1, 103, 1'b0});
    tbl.push_back(vec_t'{100, 1'b1, 100, 1'b0});
    tbl.push_back(vec_t'{98,  1'b1, 98,  1'b0});
    tbl.push_back(vec_t'{102, 1'b1, 102, 1'b1});
    tbl.push_back(vec_t'{150, 1'b1, 150, 1'b0});
    tbl.push_back(vec_t'{151, 1'b0, 150, 1'b0});
    tbl.push_back(vec_t'{7,   1'b1, 7,   1'b0});

    // Reset state.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("reset_outputs", 64'({O_PERIOD, O_VALID, O_LOCK, O_TIMEOUT}), 64'(0));

    // Vector table: periods, lock rise/fall, edge-at-timeout, edge after timeout.
    foreach (tbl[i]) begin
      pulse_after(tbl[i].gap);
      chk($sformatf("vec%0d_valid", i),  64'(O_VALID),  64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_period", i), 64'(O_PERIOD), 64'(tbl[i].exp_period));
      chk($sformatf("vec%0d_lock", i),   64'(O_LOCK),   64'(tbl[i].exp_lock));
    end

    // Acquire lock, then let edges stop: timeout exactly TMO cycles later, lock cleared.
    repeat (3) pulse_after(100);
    chk("lock_before_timeout", 64'(O_LOCK), 64'(1));
    to_at      = -1;
    to_cnt     = 0;
    lock_at_to = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick(1'b0, 1'b0);
      if (O_TIMEOUT) begin
        to_cnt++;
        if (to_at < 0) begin
          to_at      = k;
          lock_at_to = O_LOCK;
        end
      end
    end
    chk("timeout_cycle", 64'(to_at), 64'(TMO));
    chk("timeout_count", 64'(to_cnt), 64'(1));
    chk("timeout_lock",  64'(lock_at_to), 64'(0));
    pulse_after(3);
    chk("after_to_no_valid", 64'(O_VALID), 64'(0));
    pulse_after(7);
    chk("after_to_period", 64'({O_VALID, O_PERIOD}), 64'({1'b1, 17'd7}));

    // Reset in the middle of a period.
    repeat (2) pulse_after(100);
    repeat (50) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("midreset_outputs", 64'({O_PERIOD, O_VALID, O_LOCK, O_TIMEOUT}), 64'(0));
    pulse_after(3);
    chk("midreset_first_edge", 64'(O_VALID), 64'(0));
    pulse_after(100);
    chk("midreset_period", 64'({O_VALID, O_PERIOD, O_LOCK}), 64'({1'b1, 17'd100, 1'b0}));

    // Pulse held high through reset release counts as an edge right after reset.
    tick(1'b1, 1'b1);
    repeat (5) tick(1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("held_high_period", 64'({O_VALID, O_PERIOD}), 64'({1'b1, 17'd20}));

    // 10-high/10-low square wave: one report per rising edge, period 20.
    repeat (9) tick(1'b1, 1'b0);
    nv  = 0;
    bad = 0;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 20; c++) begin
        tick((c >= 10) ? 1'b1 : 1'b0, 1'b0);
        if (O_VALID) begin
          nv++;
          if (O_PERIOD != 17'd20) bad++;
        end
      end
    end
    chk("square_valid_count", 64'(nv), 64'(5));
    chk("square_bad_period", 64'(bad), 64'(0));

    // Randomized pulse trains with occasional resets, checked every cycle by the model.
    for (int s = 0; s < 300; s++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 45)      total = int'($urandom_range(97, 103));
      else if (sel < 65) total = int'($urandom_range(2, 12));
      else if (sel < 80) total = int'($urandom_range(148, 153));
      else               total = int'($urandom_range(2, 260));
      hi = int'($urandom_range(1, total - 1));
      for (int c = 0; c < total; c++) begin
        if ($urandom_range(0, 999) == 0) begin
          tick(1'($urandom_range(0, 1)), 1'b1);
        end else begin
          tick((c < hi) ? 1'b1 : 1'b0, 1'b0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
